// File: rtl/alu_issue_queue.sv
// Issue stage for the 4-bit ALU: a small operand FIFO feeding the ALU inputs and
// a registered result slot, each side with its own valid/ready handshake.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_a,
  input  logic [3:0]    in_b,
  input  logic [1:0]    in_sel,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [1:0]    alu_sel,
  input  logic [3:0]    alu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [3:0]    res_data,
  output logic [1:0]    res_sel,
  output logic [AW:0]   count,
  output logic [7:0]    issued_cnt
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [3:0]    memA_q   [DEPTH];
  logic [3:0]    memB_q   [DEPTH];
  logic [1:0]    memSel_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          resValid_q, resValid_d;
  logic [3:0]    resData_q, resData_d;
  logic [1:0]    resSel_q, resSel_d;
  logic [7:0]    issued_q, issued_d;
  logic          push, pop, notEmpty;

  // Handshakes use the registered occupancy only, so a full queue never
  // accepts even when the head leaves in the same cycle.
  always_comb begin
    notEmpty = (count_q != '0);
    in_ready = (count_q != FULL);
    push     = in_valid & in_ready;
    pop      = notEmpty & (~resValid_q | res_ready);

    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (notEmpty) begin
      alu_a   = memA_q[rdPtr_q];
      alu_b   = memB_q[rdPtr_q];
      alu_sel = memSel_q[rdPtr_q];
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    resValid_d = resValid_q;
    resData_d  = resData_q;
    resSel_d   = resSel_q;
    issued_d   = issued_q;

    if (push) wrPtr_d = wrPtr_q + AW'(1);

    if (pop) begin
      rdPtr_d    = rdPtr_q + AW'(1);
      resValid_d = 1'b1;
      resData_d  = alu_out;
      resSel_d   = memSel_q[rdPtr_q];
      issued_d   = issued_q + 8'd1;
    end else if (resValid_q && res_ready) begin
      resValid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage needs no reset: empty slots are masked off the ALU inputs.
  always_ff @(posedge clk) begin
    if (push) begin
      memA_q[wrPtr_q]   <= in_a;
      memB_q[wrPtr_q]   <= in_b;
      memSel_q[wrPtr_q] <= in_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resSel_q   <= '0;
      issued_q   <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      resValid_q <= resValid_d;
      resData_q  <= resData_d;
      resSel_q   <= resSel_d;
      issued_q   <= issued_d;
    end
  end

  assign res_valid  = resValid_q;
  assign res_data   = resData_q;
  assign res_sel    = resSel_q;
  assign count      = count_q;
  assign issued_cnt = issued_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: a queue-level reference model predicts
// occupancy and results, and a separate monitor checks each consumed result.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
  } op_t;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [3:0]    in_a, in_b;
  logic [1:0]    in_sel;
  logic [3:0]    alu_a, alu_b, alu_out;
  logic [1:0]    alu_sel;
  logic          res_valid, res_ready;
  logic [3:0]    res_data;
  logic [1:0]    res_sel;
  logic [AW:0]   count;
  logic [7:0]    issued_cnt;

  int checks = 0;
  int errors = 0;

  op_t        mQ[$];
  logic [5:0] sbQ[$];
  logic       mResValid = 1'b0;
  logic [7:0] mIssued = 8'd0;
  bit         accepted = 1'b0;
  int         rrMode = 0;

  function automatic logic [3:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] sel);
    case (sel)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return 4'(a + b);
      default: return 4'(a * b);
    endcase
  endfunction

  assign alu_out = aluRef(alu_a, alu_b, alu_sel);

  alu_issue_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_sel(res_sel),
    .count(count), .issued_cnt(issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle, predicts what the next edge does.
  always @(negedge clk) begin
    op_t  head;
    bit   pushM, popM;
    if (rst) begin
      mQ.delete();
      mResValid = 1'b0;
      mIssued   = 8'd0;
      accepted  = 1'b0;
    end else begin
      head = (mQ.size() != 0) ? mQ[0] : '0;
      checkOutput("count", int'(count), mQ.size());
      checkOutput("in_ready", int'(in_ready), int'(mQ.size() != DEPTH));
      checkOutput("res_valid", int'(res_valid), int'(mResValid));
      checkOutput("issued_cnt", int'(issued_cnt), int'(mIssued));
      checkOutput("alu_a", int'(alu_a), int'(head.a));
      checkOutput("alu_b", int'(alu_b), int'(head.b));
      checkOutput("alu_sel", int'(alu_sel), int'(head.sel));

      pushM = in_valid && (mQ.size() < DEPTH);
      popM  = (mQ.size() != 0) && (!mResValid || res_ready);
      if (popM) begin
        void'(mQ.pop_front());
        mResValid = 1'b1;
        mIssued   = mIssued + 8'd1;
      end else if (mResValid && res_ready) begin
        mResValid = 1'b0;
      end
      if (pushM) begin
        mQ.push_back({in_a, in_b, in_sel});
        sbQ.push_back({aluRef(in_a, in_b, in_sel), in_sel});
      end
      accepted = pushM;
    end
  end

  // Monitor: pops the scoreboard whenever a result is handed to the consumer.
  logic [3:0] heldData;
  logic [1:0] heldSel;
  bit         stallPrev = 1'b0;
  always @(negedge clk) begin
    logic [5:0] exp;
    if (rst) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("stall_data", int'(res_data), int'(heldData));
        checkOutput("stall_sel", int'(res_sel), int'(heldSel));
      end
      if (res_valid && res_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_empty: got result %0d expected none at %0t", res_data, $time);
        end else begin
          exp = sbQ.pop_front();
          checkOutput("res_data", int'(res_data), int'(exp[5:2]));
          checkOutput("res_sel", int'(res_sel), int'(exp[1:0]));
        end
      end
      stallPrev = res_valid && !res_ready;
      heldData  = res_data;
      heldSel   = res_sel;
    end
  end

  // Consumer ready pattern: 0 always ready, 1 stalled, 2 random.
  always @(posedge clk) begin
    #1;
    case (rrMode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'b0;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      idle(1);
      if (accepted) begin
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL accept_timeout: got no handshake expected one at %0t", $time);
    in_valid = 1'b0;
  endtask

  task automatic applyReset();
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_res_valid", int'(res_valid), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_alu", int'({alu_a, alu_b, alu_sel}), 0);
    checkOutput("rst_issued", int'(issued_cnt), 0);
    checkOutput("rst_res_data", int'(res_data), 0);
    mQ.delete();
    sbQ.delete();
    mResValid = 1'b0;
    mIssued   = 8'd0;
    accepted  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sbQ.size() == 0 && mQ.size() == 0 && !mResValid) return;
      idle(1);
    end
    checks++;
    errors++;
    $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sbQ.size());
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Single ADD 3+5 and the AND/OR/MUL back-to-back sequence.
    applyStimulus(4'd3, 4'd5, 2'b10);
    idle(2);
    applyStimulus(4'b1100, 4'b1010, 2'b00);
    applyStimulus(4'b0011, 4'b0100, 2'b01);
    applyStimulus(4'b0100, 4'b0101, 2'b11);
    drain();

    // Stalled consumer: five fit, sixth is held until the consumer resumes.
    rrMode = 1;
    idle(1);
    for (int i = 0; i < 5; i++) applyStimulus(4'(i + 1), 4'(i + 7), 2'(i));
    in_a = 4'd9; in_b = 4'd9; in_sel = 2'b11; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checkOutput("full_held", int'(accepted), 0);
    end
    rrMode = 0;
    applyStimulus(4'd9, 4'd9, 2'b11);
    drain();

    // Steady push and pop across the pointer wrap.
    for (int i = 0; i < 10; i++) applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'(i));
    drain();

    // Reset while three entries wait and a result is held.
    rrMode = 1;
    idle(1);
    for (int i = 0; i < 4; i++) applyStimulus(4'(i + 2), 4'(i + 3), 2'b10);
    applyReset();
    rrMode = 2;

    // Random burst with a toggling consumer; long enough to wrap issued_cnt.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rrMode = 0;
    drain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
